// File: rtl/l_seq_pkg.sv
// Shared types and constants for the L-frame sequencer.
// Build option L_SEQ_FIRST_POS_EN is consumed by l_frame_sequencer, not here.
package l_seq_pkg;

    typedef logic [2:0] col_t;

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_DISCARD = 3'd1,
        S_PLAY    = 3'd2,
        S_STREAM  = 3'd3,
        S_FLUSH   = 3'd4,
        S_SETTLE  = 3'd5,
        S_REPORT  = 3'd6
    } seq_state_e;

    localparam col_t BLANK = 3'b000;

endpackage

// File: rtl/l_seq_colbuf.sv
// Frame column store: MAX_COLS x 3-bit register file, synchronous write, asynchronous read.
module l_seq_colbuf
    import l_seq_pkg::*;
#(
    parameter int MAX_COLS = 16
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(MAX_COLS)-1:0]   waddr,
    input  col_t                          wdata,
    input  logic [$clog2(MAX_COLS)-1:0]   raddr,
    output col_t                          rdata
);

    col_t mem_q [MAX_COLS];

    // Column write port; contents need no reset since the write pointer bounds every read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/l_frame_sequencer.sv
// Buffers a column frame, replays it to the L recognizer and reports the detection count.
// Optional macro L_SEQ_FIRST_POS_EN adds out_first (1-based column of the first detection).
module l_frame_sequencer
    import l_seq_pkg::*;
#(
    parameter int MAX_COLS = 16,
    parameter int CNT_W    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [2:0]                  in_bits,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [2:0]                  rd_bits,
    output logic                        rd_restart,
    input  logic                        rd_L,
    output logic                        out_valid,
    output logic [CNT_W-1:0]            out_count,
    output logic [$clog2(MAX_COLS):0]   out_cols,
    output logic                        out_ovf,
`ifdef L_SEQ_FIRST_POS_EN
    output logic [$clog2(MAX_COLS):0]   out_first,
`endif
    input  logic                        out_ready
);

    localparam int AW = $clog2(MAX_COLS);
    localparam int PW = AW + 1;

    seq_state_e         state_q, state_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               l_prev_q, l_prev_d;
    logic               in_ready_q, in_ready_d;
    col_t               rd_bits_q, rd_bits_d;
    logic               rd_restart_q, rd_restart_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic [PW-1:0]      out_cols_q, out_cols_d;
    logic               out_ovf_q, out_ovf_d;
    logic               accept_s, buf_we_s, sample_s, det_s;
    col_t               buf_rdata_s;

    l_seq_colbuf #(.MAX_COLS(MAX_COLS)) u_colbuf (
        .clk   (clk),
        .we    (buf_we_s),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (in_bits),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (buf_rdata_s)
    );

    // Next-state, pointer, counter and registered-output computation.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        l_prev_d  = l_prev_q;
        rd_bits_d = BLANK;
        buf_we_s  = 1'b0;
        sample_s  = 1'b0;
        accept_s  = in_valid & in_ready_q;

        case (state_q)
            S_LOAD: begin
                if (accept_s) begin
                    buf_we_s = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (in_last) begin
                        state_d = S_PLAY;
                    end else if (wr_ptr_q == PW'(MAX_COLS - 1)) begin
                        ovf_d   = 1'b1;
                        state_d = S_DISCARD;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DISCARD: begin
                if (accept_s && in_last) begin
                    state_d = S_PLAY;
                end else begin
                    state_d = S_DISCARD;
                end
            end
            S_PLAY: begin
                // rd_ptr_q is zero here, so the buffer already presents column 0.
                rd_bits_d = buf_rdata_s;
                rd_ptr_d  = PW'(1);
                l_prev_d  = 1'b0;
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                // rd_L lags the driven column by one cycle, so the first stream cycle is skipped.
                sample_s = (rd_ptr_q != PW'(1));
                if (rd_ptr_q == wr_ptr_q) begin
                    state_d = S_FLUSH;
                end else begin
                    rd_bits_d = buf_rdata_s;
                    rd_ptr_d  = rd_ptr_q + PW'(1);
                end
            end
            S_FLUSH: begin
                sample_s = 1'b1;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                sample_s = 1'b1;
                state_d  = S_REPORT;
            end
            S_REPORT: begin
                if (out_ready) begin
                    state_d  = S_LOAD;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                end else begin
                    state_d = S_REPORT;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        det_s = sample_s & rd_L & ~l_prev_q;
        if (sample_s) begin
            l_prev_d = rd_L;
        end else begin
            l_prev_d = l_prev_d;
        end
        if (det_s && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_d;
        end

        in_ready_d   = (state_d == S_LOAD) || (state_d == S_DISCARD);
        rd_restart_d = (state_d == S_PLAY);
        out_valid_d  = (state_d == S_REPORT);
        out_count_d  = out_valid_d ? count_d  : '0;
        out_cols_d   = out_valid_d ? wr_ptr_d : '0;
        out_ovf_d    = out_valid_d ? ovf_d    : 1'b0;
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LOAD;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            l_prev_q     <= 1'b0;
            in_ready_q   <= 1'b1;
            rd_bits_q    <= BLANK;
            rd_restart_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_count_q  <= '0;
            out_cols_q   <= '0;
            out_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            l_prev_q     <= l_prev_d;
            in_ready_q   <= in_ready_d;
            rd_bits_q    <= rd_bits_d;
            rd_restart_q <= rd_restart_d;
            out_valid_q  <= out_valid_d;
            out_count_q  <= out_count_d;
            out_cols_q   <= out_cols_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

`ifdef L_SEQ_FIRST_POS_EN
    logic [PW-1:0] first_q, first_d, idx_s, out_first_q, out_first_d;

    // Column index whose recognizer result is visible on rd_L this cycle.
    always_comb begin
        case (state_q)
            S_STREAM: idx_s = rd_ptr_q - PW'(1);
            S_FLUSH:  idx_s = wr_ptr_q;
            S_SETTLE: idx_s = wr_ptr_q + PW'(1);
            default:  idx_s = '0;
        endcase
        if ((state_q == S_REPORT) && out_ready) begin
            first_d = '0;
        end else if (det_s && (first_q == '0)) begin
            first_d = idx_s;
        end else begin
            first_d = first_q;
        end
        out_first_d = out_valid_d ? first_d : '0;
    end

    // First-detection position register.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_q     <= '0;
            out_first_q <= '0;
        end else begin
            first_q     <= first_d;
            out_first_q <= out_first_d;
        end
    end

    assign out_first = out_first_q;
`endif

    assign in_ready   = in_ready_q;
    assign rd_bits    = rd_bits_q;
    assign rd_restart = rd_restart_q;
    assign out_valid  = out_valid_q;
    assign out_count  = out_count_q;
    assign out_cols   = out_cols_q;
    assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_l_frame_sequencer.sv
// Scoreboard bench for l_frame_sequencer with a behavioural L recognizer (111 then 001).
module tb_l_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset, in_valid, in_last, in_ready, rd_restart, out_valid, out_ovf, out_ready;
    logic [2:0] in_bits, rd_bits;
    logic       rd_L = 1'b0;
    logic [3:0] out_count;
    logic [4:0] out_cols;
`ifdef L_SEQ_FIRST_POS_EN
    logic [4:0] out_first;
`endif

    l_frame_sequencer #(.MAX_COLS(16), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bits(in_bits),
        .in_last(in_last), .in_ready(in_ready), .rd_bits(rd_bits),
        .rd_restart(rd_restart), .rd_L(rd_L), .out_valid(out_valid),
        .out_count(out_count), .out_cols(out_cols), .out_ovf(out_ovf),
`ifdef L_SEQ_FIRST_POS_EN
        .out_first(out_first),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Recognizer model: Moore output, L after a 111 column followed by 001.
    logic [2:0] rec_prev = 3'b000;
    always @(posedge clk) begin
        if (reset || rd_restart) begin
            rec_prev <= 3'b000;
            rd_L     <= 1'b0;
        end else begin
            rd_L     <= (rec_prev == 3'b111) && (rd_bits == 3'b001);
            rec_prev <= rd_bits;
        end
    end

    typedef struct {
        int count;
        int cols;
        int ovf;
        int first;
        int due;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] frame [0:31];
    bit         prev_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every presented report against the scoreboard head.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_report", 1, 0);
            end else begin
                if (!prev_valid) chk("latency", cyc, sb[0].due);
                chk("count", int'(out_count), sb[0].count);
                chk("cols", int'(out_cols), sb[0].cols);
                chk("ovf", int'(out_ovf), sb[0].ovf);
`ifdef L_SEQ_FIRST_POS_EN
                chk("first", int'(out_first), sb[0].first);
`endif
                chk("in_ready_in_report", int'(in_ready), 0);
                if (out_ready) void'(sb.pop_front());
            end
        end
        prev_valid <= (out_valid === 1'b1);
    end

    task automatic set_frame(input logic [95:0] v, input int n);
        for (int i = 0; i < n; i++) frame[i] = v[3*(n-1-i) +: 3];
    endtask

    // Drives n beats; returns in the cycle after the last accept (PLAY).
    task automatic send_frame(input int n, input bit push, input int e_cnt,
                              input int e_cols, input int e_ovf, input int e_first);
        int   waited;
        int   acc_cyc;
        exp_t e;
        acc_cyc = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_bits  = frame[i];
            in_last  = (i == n - 1);
            waited   = 0;
            @(negedge clk);
            while (!in_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            chk("in_ready_beat", waited, 0);
            acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bits  = 3'b000;
        if (push) begin
            e.count = e_cnt;
            e.cols  = e_cols;
            e.ovf   = e_ovf;
            e.first = e_first;
            e.due   = acc_cyc + e_cols + 4;
            sb.push_back(e);
        end
    endtask

    task automatic check_replay(input int n);
        @(negedge clk);
        chk("restart_pulse", int'(rd_restart), 1);
        chk("restart_bits", int'(rd_bits), 0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("replay_col", int'(rd_bits), int'(frame[k]));
            chk("replay_no_restart", int'(rd_restart), 0);
        end
        @(negedge clk);
        chk("flush_blank", int'(rd_bits), 0);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain", sb.size(), 0);
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset = 1'b1; in_valid = 1'b0; in_bits = 3'b000; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_rd_bits", int'(rd_bits), 0);
        chk("rst_rd_restart", int'(rd_restart), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_out_cols", int'(out_cols), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);
        @(posedge clk);
        #1;

        // Basic frame with full replay check.
        set_frame(96'o0710, 4);
        send_frame(4, 1'b1, 1, 4, 0, 3);
        check_replay(4);
        drain();

        // Two detections, eight columns, latency 12.
        set_frame(96'o07110710, 8);
        send_frame(8, 1'b1, 2, 8, 0, 3);
        drain();

        // 20-column frame truncated to 16.
        set_frame(96'o71717171717171717171, 20);
        send_frame(20, 1'b1, 8, 16, 1, 2);
        check_replay(16);
        drain();

        // Report stalled for five cycles, handshake on the sixth.
        out_ready = 1'b0;
        set_frame(96'o71, 2);
        send_frame(2, 1'b1, 1, 2, 0, 2);
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("stall_report_seen", int'(out_valid), 1);
        repeat (4) @(posedge clk);
        #1;
        chk("stall_still_pending", sb.size(), 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Single-column frame after the stall: counters were cleared.
        set_frame(96'o0, 1);
        send_frame(1, 1'b1, 0, 1, 0, 0);
        drain();

        // Reset in the middle of STREAM aborts the frame with no report.
        set_frame(96'o717171, 6);
        send_frame(6, 1'b0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_rd_bits", int'(rd_bits), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_rd_restart", int'(rd_restart), 0);
        @(posedge clk);
        #1;
        repeat (12) @(posedge clk);
        #1;

        set_frame(96'o710, 3);
        send_frame(3, 1'b1, 1, 3, 0, 2);
        drain();

        // First-detection position and an all-blank frame.
        set_frame(96'o00710, 5);
        send_frame(5, 1'b1, 1, 5, 0, 4);
        drain();
        set_frame(96'o000, 3);
        send_frame(3, 1'b1, 0, 3, 0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
